// File: rtl/knn_pkg.sv
// Shared types and sizing for the k-NN distance stage.
// Used by knn_distance_calc and knn_diff_metric.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT,
    FINISH
  } state_t;

  localparam int DATA_W = 32;
  localparam int FEAT_W = 16;
  localparam int NUM_F  = 4;

  function automatic int term_width(input int fw);
    return 2 * fw + 2;
  endfunction

endpackage

// File: rtl/knn_diff_metric.sv
// Per-element distance term: squared difference, or |diff|
// when KNN_MANHATTAN_EN is defined.
module knn_diff_metric
  import knn_pkg::*;
#(
  parameter int featureWidth = FEAT_W,
  localparam int TW = term_width(featureWidth)
) (
  input  logic signed [featureWidth-1:0] sample,
  input  logic signed [featureWidth-1:0] query,
  output logic        [TW-1:0]           term
);

  logic signed [featureWidth:0] diff;

  assign diff = {sample[featureWidth-1], sample}
              - {query[featureWidth-1], query};

`ifdef KNN_MANHATTAN_EN
  logic [featureWidth:0] mag;

  // |diff| always fits: the extra bit leaves room for the magnitude
  assign mag  = diff[featureWidth] ? -diff : diff;
  assign term = TW'(mag);
`else
  logic signed [TW-1:0] wide;
  logic signed [TW-1:0] sq;

  assign wide = TW'(diff);
  assign sq   = wide * wide;
  assign term = $unsigned(sq);
`endif

endmodule

// File: rtl/knn_distance_calc.sv
// Streams sample vectors against a stored query, emitting one
// saturated distance per sample. Metric: KNN_MANHATTAN_EN.
module knn_distance_calc
  import knn_pkg::*;
#(
  parameter int dataWidth    = DATA_W,
  parameter int featureWidth = FEAT_W,
  parameter int numFeatures  = NUM_F,
  localparam int IW = (numFeatures > 1) ? $clog2(numFeatures) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    query_wr,
  input  logic [IW-1:0]           query_idx,
  input  logic [featureWidth-1:0] query_data,
  input  logic                    start,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [featureWidth-1:0] sample_data,
  input  logic                    sample_last,
  output logic                    valid,
  output logic                    done,
  output logic                    error,
  output logic [31:0]             dataNameOut,
  output logic [dataWidth-1:0]    dataValueOut
);

  localparam int TW = term_width(featureWidth);
  localparam int SW = ((dataWidth > TW) ? dataWidth : TW) + 1;

  state_t state;
  state_t state_next;

  logic [featureWidth-1:0] query [numFeatures];
  logic [dataWidth-1:0]    acc;
  logic [dataWidth-1:0]    acc_next;
  logic [IW-1:0]           idx;
  logic [31:0]             name;
  logic                    last_seen;
  logic [TW-1:0]           term;
  logic [SW-1:0]           sum;
  logic                    accept;
  logic                    end_vec;

  assign sample_ready = (state == ACCUM);
  assign accept       = sample_valid && sample_ready;
  assign end_vec      = (idx == IW'(numFeatures - 1));
  assign valid        = (state == EMIT);
  assign done         = (state == FINISH);

  knn_diff_metric #(
    .featureWidth(featureWidth)
  ) u_metric (
    .sample(sample_data),
    .query (query[idx]),
    .term  (term)
  );

  // Any carry above dataWidth clamps to all-ones
  always_comb begin
    sum      = SW'(acc) + SW'(term);
    acc_next = sum[dataWidth-1:0];
    if (|(sum >> dataWidth)) acc_next = '1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (start) state_next = ACCUM;
      ACCUM:
        if (accept) begin
          if (end_vec)          state_next = EMIT;
          else if (sample_last) state_next = FINISH;
        end
      EMIT:
        state_next = last_seen ? FINISH : ACCUM;
      FINISH:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      acc          <= '0;
      idx          <= '0;
      name         <= '0;
      last_seen    <= 1'b0;
      error        <= 1'b0;
      dataNameOut  <= '0;
      dataValueOut <= '0;
      for (int i = 0; i < numFeatures; i++)
        query[i] <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (query_wr && int'(query_idx) < numFeatures)
            query[query_idx] <= query_data;
          if (start) begin
            acc       <= '0;
            idx       <= '0;
            name      <= '0;
            error     <= 1'b0;
            last_seen <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (end_vec) begin
              dataNameOut  <= name;
              dataValueOut <= acc_next;
              name         <= name + 32'd1;
              acc          <= '0;
              idx          <= '0;
              last_seen    <= sample_last;
            end else if (sample_last) begin
              acc   <= '0;
              idx   <= '0;
              error <= 1'b1;
            end else begin
              acc <= acc_next;
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
